cheat_loader: RTL
=================

Name: cheat_loader

Overview:
- Producer side of the cheat-code interface.
- Receives the host's cheat-file download as a byte stream and packs each 16-byte record into a CODE_WIDTH-bit code word.
- Presents each word to the Game Genie/cheat engine with a one-cycle load strobe on bit 128.
- Pulses a clear at the start of every download and tracks code count, overflow and truncated records.

Parameters:
- CODE_WIDTH, 129: code word width; bits [127:0] hold the record, bit 128 is the load strobe.
- BYTES_PER_CODE, 16: bytes per record; BYTES_PER_CODE*8 must equal CODE_WIDTH-1.
- MAX_CODES, 16: capacity of the cheat engine; records beyond this are dropped.
- COUNT_WIDTH, 5: width of code_count; must hold MAX_CODES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- dl_active  in  1  cheat download window is open (host download flag, already qualified by file index).
- dl_wr  in  1  byte strobe; one byte per cycle while high.
- dl_data  in  8  download byte.
- code  out  CODE_WIDTH  [127:0] = last completed record; [128] = load strobe.
- codes_clear  out  1  one-cycle pulse; the cheat engine discards all stored codes.
- code_count  out  COUNT_WIDTH  records delivered in the current download.
- overflow  out  1  sticky; a complete record arrived after MAX_CODES had been delivered.
- trunc_err  out  1  sticky; download ended partway through a record.
- busy  out  1  FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs 0, byte index 0, FSM IDLE, assembly register 0.
- All outputs are registered.
- FSM states: IDLE, CLEAR, COLLECT, EMIT.
- IDLE -> CLEAR when dl_active=1 (the rising edge is seen directly from IDLE).
- CLEAR, one cycle:
  - codes_clear=1; code_count, overflow, trunc_err and byte index cleared.
  - A dl_wr in this cycle is accepted as byte 0.
  - Next state is COLLECT.
- COLLECT:
  - Each dl_wr writes dl_data into bits [8*idx+7:8*idx] of the assembly register, then idx increments. Byte 0 is the LSB.
  - If idx=BYTES_PER_CODE-1 when the byte is accepted, go to EMIT and reset idx to 0.
- EMIT, one cycle:
  - If code_count<MAX_CODES: code[127:0] <= assembled record, code[128]=1 for exactly this cycle, code_count increments.
  - Otherwise: overflow <= 1, no strobe, code[127:0] unchanged.
  - A dl_wr in the EMIT cycle is accepted as byte 0 of the next record, so full-rate input needs no backpressure.
  - Next state is COLLECT, or IDLE if dl_active=0.
- dl_active falls while in COLLECT:
  - If idx!=0: trunc_err <= 1 and the partial record is discarded.
  - Return to IDLE.
  - Any dl_wr in that same cycle is ignored.
- dl_active falls during EMIT: the emit completes, then IDLE.
- dl_wr with dl_active=0 is ignored in every state.
- code[128] is low in every cycle other than a successful EMIT.
- code[127:0] holds its value between strobes and across downloads, until the next successful EMIT.
- code_count saturates at MAX_CODES.
- overflow and trunc_err clear only in CLEAR or on reset.
- Latency: the strobe appears the cycle after the final byte of a record is accepted. Consecutive strobes at full byte rate are BYTES_PER_CODE cycles apart.
- reset_n asserted mid-record: everything returns to reset values immediately. The partial record is lost and no strobe is produced.
- A download that starts while dl_active is already high at reset release is handled normally (IDLE -> CLEAR).

Decomposition:
- Package cheat_pkg holds:
  - CODE_WIDTH, BYTES_PER_CODE, MAX_CODES;
  - the strobe-bit index localparam (CODE_WIDTH-1);
  - the state enum typedef (IDLE, CLEAR, COLLECT, EMIT).
- No sub-module is warranted; the byte-lane assembly register is a single always block inside cheat_loader.

Test Plan:
- One download of bytes 0x00..0x0F at one per cycle -> one codes_clear pulse at start; code[127:0]=0x0F0E0D0C0B0A09080706050403020100; code[128] high exactly one cycle, the cycle after byte 0x0F; code_count=1.
- 32 bytes back-to-back -> two strobes exactly 16 cycles apart; code_count=2; no byte lost across the EMIT cycle.
- 17 full records with MAX_CODES=16 -> 16 strobes; overflow=1; code_count=16; code[127:0] equals record 16.
- 7 bytes then dl_active=0 -> no strobe; trunc_err=1; a following download pulses codes_clear and clears trunc_err and code_count.
- dl_wr pulses with dl_active=0, including 16 bytes -> no strobe, no count change, busy=0.
- reset_n low after 9 bytes -> all outputs 0 asynchronously; after release, a new 16-byte download yields exactly one correct record with no carry-over of old bytes.

Source files
------------

// File: rtl/cheat_pkg.sv
// cheat_pkg: shared constants and state type for the cheat-code loader.
//   CODE_WIDTH     - code word width; [127:0] record, [128] load strobe
//   BYTES_PER_CODE - bytes per cheat record (byte 0 is the LSB)
//   MAX_CODES      - cheat engine capacity; further records are dropped
//   COUNT_WIDTH    - width of the delivered-record counter
//   state_t        - loader FSM states
package cheat_pkg;

  localparam int unsigned CODE_WIDTH     = 129;
  localparam int unsigned BYTES_PER_CODE = 16;
  localparam int unsigned MAX_CODES      = 16;
  localparam int unsigned COUNT_WIDTH    = 5;

  localparam int unsigned STROBE_BIT = CODE_WIDTH - 1;
  localparam int unsigned REC_WIDTH  = BYTES_PER_CODE * 8;
  localparam int unsigned IDX_WIDTH  = $clog2(BYTES_PER_CODE);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    COLLECT,
    EMIT
  } state_t;

endpackage

// File: rtl/cheat_loader.sv
// cheat_loader: packs a host cheat-file byte stream into code words for the
// cheat engine.
//   clk, reset_n  - clock, asynchronous active-low reset
//   dl_active     - download window open
//   dl_wr/dl_data - one download byte per cycle while dl_wr is high
//   code          - [127:0] last delivered record, [128] one-cycle load strobe
//   codes_clear   - one-cycle pulse at the start of every download
//   code_count    - records delivered in the current download (saturating)
//   overflow      - sticky: a full record arrived with the engine already full
//   trunc_err     - sticky: download ended partway through a record
//   busy          - FSM is not idle
module cheat_loader
  import cheat_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   dl_active,
  input  logic                   dl_wr,
  input  logic [7:0]             dl_data,
  output logic [CODE_WIDTH-1:0]  code,
  output logic                   codes_clear,
  output logic [COUNT_WIDTH-1:0] code_count,
  output logic                   overflow,
  output logic                   trunc_err,
  output logic                   busy
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BYTES_PER_CODE - 1);

  state_t               state;
  logic [IDX_WIDTH-1:0] idx;
  logic [REC_WIDTH-1:0] asm_reg;
  logic [REC_WIDTH-1:0] rec_next;
  logic                 byte_ok;
  logic                 can_store;

  assign byte_ok   = dl_active & dl_wr;
  assign can_store = (code_count < COUNT_WIDTH'(MAX_CODES));

  // Assembly register with the incoming byte merged into its lane, so the final
  // byte of a record can be delivered on the same edge that accepts it.
  always_comb begin
    rec_next = asm_reg;
    rec_next[{idx, 3'b000} +: 8] = dl_data;
  end

  // Outputs are updated on the edge that enters a state, so codes_clear is
  // visible during the CLEAR cycle and the load strobe during the EMIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      asm_reg     <= '0;
      code        <= '0;
      codes_clear <= 1'b0;
      code_count  <= '0;
      overflow    <= 1'b0;
      trunc_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      codes_clear      <= 1'b0;
      code[STROBE_BIT] <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dl_active) begin
            state       <= CLEAR;
            busy        <= 1'b1;
            codes_clear <= 1'b1;
            code_count  <= '0;
            overflow    <= 1'b0;
            trunc_err   <= 1'b0;
            idx         <= '0;
          end
        end
        CLEAR: begin
          state <= COLLECT;
          if (byte_ok) begin
            asm_reg <= rec_next;
            idx     <= idx + 1'b1;
          end
        end
        COLLECT: begin
          if (!dl_active) begin
            if (idx != '0) begin
              trunc_err <= 1'b1;
            end
            idx   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (dl_wr) begin
            asm_reg <= rec_next;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= EMIT;
              if (can_store) begin
                code       <= {1'b1, rec_next};
                code_count <= code_count + 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        EMIT: begin
          // idx is already 0 here, so a byte in this cycle starts the next record.
          if (dl_active) begin
            state <= COLLECT;
            if (dl_wr) begin
              asm_reg <= rec_next;
              idx     <= idx + 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
